// File: rtl/mu0_control_pkg.sv
// Shared MU0 control constants: opcodes, FSM state encodings, ALU codes, selects.
// Consumed by mu0_decode and mu0_control.
package mu0_control_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    localparam logic [1:0] FS_Y   = 2'b00;
    localparam logic [1:0] FS_ADD = 2'b01;
    localparam logic [1:0] FS_INC = 2'b10;
    localparam logic [1:0] FS_SUB = 2'b11;

    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;
    localparam logic X_ACC   = 1'b0;
    localparam logic X_PC    = 1'b1;
    localparam logic Y_DIN   = 1'b0;
    localparam logic Y_IMM   = 1'b1;

    typedef struct packed {
        logic       addr_sel;
        logic       x_sel;
        logic       y_sel;
        logic [1:0] alu_fs;
        logic       acc_ce;
        logic       pc_ce;
        logic       ir_ce;
        logic       acc_oe;
        logic       mem_req;
        logic       rnw;
        logic       halted;
    } ctrl_t;

    // Quiescent vector: no enables, no request, read direction.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c     = '0;
        c.rnw = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mu0_control_decode.sv
// mu0_decode: combinational EXEC-state decoder (opcode, flags, mem_rdy -> controls).
// With MU0_ILLEGAL_TRAP_EN defined, opcodes 8-F route to HALT instead of FETCH.
module mu0_decode
    import mu0_control_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    input  logic            n_flag,
    input  logic            z_flag,
    input  logic            mem_rdy,
    output ctrl_t           ctrl,
    output logic [1:0]      next_state
);

    always_comb begin
        ctrl       = ctrl_idle();
        next_state = ST_FETCH;
        case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
                ctrl.addr_sel = ADDR_IR;
                ctrl.mem_req  = 1'b1;
                ctrl.y_sel    = Y_DIN;
                ctrl.x_sel    = X_ACC;
                ctrl.alu_fs   = (opcode == OP_ADD) ? FS_ADD :
                                (opcode == OP_SUB) ? FS_SUB : FS_Y;
                ctrl.acc_ce   = mem_rdy;
                if (!mem_rdy) next_state = ST_EXEC;
            end
            OP_STA: begin
                ctrl.addr_sel = ADDR_IR;
                ctrl.mem_req  = 1'b1;
                ctrl.rnw      = 1'b0;
                ctrl.acc_oe   = 1'b1;
                if (!mem_rdy) next_state = ST_EXEC;
            end
            OP_JMP, OP_JGE, OP_JNE: begin
                ctrl.y_sel  = Y_IMM;
                ctrl.alu_fs = FS_Y;
                ctrl.pc_ce  = (opcode == OP_JGE) ? ~n_flag :
                              (opcode == OP_JNE) ? ~z_flag : 1'b1;
            end
            OP_STP: next_state = ST_HALT;
            default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
                next_state = ST_HALT;
`else
                next_state = ST_FETCH;
`endif
            end
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute FSM with memory wait states.
// Optional MU0_ILLEGAL_TRAP_EN adds the sticky 'illegal' output for opcodes 8-F.
module mu0_control
    import mu0_control_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            n_flag,
    input  logic            z_flag,
    input  logic            mem_rdy,
    output logic            addr_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic [1:0]      alu_fs,
    output logic            acc_ce,
    output logic            pc_ce,
    output logic            ir_ce,
    output logic            acc_oe,
    output logic            mem_req,
    output logic            rnw,
    output logic            halted
`ifdef MU0_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    logic [1:0] state_q, state_d;
    logic [1:0] dec_next;
    ctrl_t      dec_ctrl, ctrl;

    mu0_decode #(.OP_W(OP_W)) u_decode (
        .opcode     (opcode),
        .n_flag     (n_flag),
        .z_flag     (z_flag),
        .mem_rdy    (mem_rdy),
        .ctrl       (dec_ctrl),
        .next_state (dec_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl    = ctrl_idle();
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                ctrl.addr_sel = ADDR_PC;
                ctrl.mem_req  = 1'b1;
                ctrl.x_sel    = X_PC;
                ctrl.alu_fs   = FS_INC;
                ctrl.ir_ce    = mem_rdy;
                ctrl.pc_ce    = mem_rdy;
                if (mem_rdy) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ctrl    = dec_ctrl;
                state_d = dec_next;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase
        // Reset masks the outputs directly so a pending request drops without waiting for a clock.
        if (reset) ctrl = ctrl_idle();
    end

    assign addr_sel = ctrl.addr_sel;
    assign x_sel    = ctrl.x_sel;
    assign y_sel    = ctrl.y_sel;
    assign alu_fs   = ctrl.alu_fs;
    assign acc_ce   = ctrl.acc_ce;
    assign pc_ce    = ctrl.pc_ce;
    assign ir_ce    = ctrl.ir_ce;
    assign acc_oe   = ctrl.acc_oe;
    assign mem_req  = ctrl.mem_req;
    assign rnw      = ctrl.rnw;
    assign halted   = ctrl.halted;

`ifdef MU0_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          illegal_q <= 1'b0;
        else if (state_q == ST_EXEC && opcode[OP_W-1])      illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: instruction-level reference model, random programs.
// Build with MU0_ILLEGAL_TRAP_EN to exercise the illegal-opcode trap.
module tb_mu0_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       n_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       mem_rdy = 1'b1;
    logic       addr_sel, x_sel, y_sel, acc_ce, pc_ce, ir_ce, acc_oe, mem_req, rnw, halted;
    logic [1:0] alu_fs;
`ifdef MU0_ILLEGAL_TRAP_EN
    logic       illegal;
    logic       ill_model = 1'b0;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    mu0_control #(.OP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .n_flag   (n_flag),
        .z_flag   (z_flag),
        .mem_rdy  (mem_rdy),
        .addr_sel (addr_sel),
        .x_sel    (x_sel),
        .y_sel    (y_sel),
        .alu_fs   (alu_fs),
        .acc_ce   (acc_ce),
        .pc_ce    (pc_ce),
        .ir_ce    (ir_ce),
        .acc_oe   (acc_oe),
        .mem_req  (mem_req),
        .rnw      (rnw),
        .halted   (halted)
`ifdef MU0_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Vector order: {halted, rnw, mem_req, acc_oe, ir_ce, pc_ce, acc_ce, alu_fs, y_sel, x_sel, addr_sel}
    function automatic logic [11:0] vec(input bit as, input bit xs, input bit ys, input bit [1:0] fs,
                                        input bit acc, input bit pc, input bit ir, input bit oe,
                                        input bit req, input bit rd, input bit hlt);
        return {hlt, rd, req, oe, ir, pc, acc, fs, ys, xs, as};
    endfunction

    function automatic logic [11:0] observed();
        return {halted, rnw, mem_req, acc_oe, ir_ce, pc_ce, acc_ce, alu_fs, y_sel, x_sel, addr_sel};
    endfunction

    function automatic logic [11:0] v_idle();
        return vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    function automatic logic [11:0] v_halt();
        return vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    endfunction

    function automatic logic [11:0] v_fetch(input bit rdy);
        return vec(0, 1, 0, 2'b10, 0, rdy, rdy, 0, 1, 1, 0);
    endfunction

    // Expected EXEC-cycle controls, written per instruction class.
    function automatic logic [11:0] v_exec(input int op, input bit rdy, input bit n, input bit z);
        bit [1:0] fs;
        if (op <= 3) begin
            fs = (op == 2) ? 2'b01 : (op == 3) ? 2'b11 : 2'b00;
            if (op == 1) return vec(1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0);
            return vec(1, 0, 0, fs, rdy, 0, 0, 0, 1, 1, 0);
        end
        if (op == 4) return vec(0, 0, 1, 2'b00, 0, 1,  0, 0, 0, 1, 0);
        if (op == 5) return vec(0, 0, 1, 2'b00, 0, !n, 0, 0, 0, 1, 0);
        if (op == 6) return vec(0, 0, 1, 2'b00, 0, !z, 0, 0, 0, 1, 0);
        return v_idle();
    endfunction

    task automatic cycle_check(input string tag, input logic [11:0] exp);
        @(negedge clk);
        check(tag, {4'b0, observed()}, {4'b0, exp});
`ifdef MU0_ILLEGAL_TRAP_EN
        check({tag, "_illegal"}, {15'b0, illegal}, {15'b0, ill_model});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
`ifdef MU0_ILLEGAL_TRAP_EN
        ill_model = 1'b0;
`endif
        #1;
        check("reset_async", {4'b0, observed()}, {4'b0, v_idle()});
        repeat (3) begin
            mem_rdy = 1'($urandom);
            opcode  = 4'($urandom);
            cycle_check("reset", v_idle());
        end
        reset = 1'b0;
    endtask

    // One instruction: fetch with fw wait cycles, exec with ew wait cycles (memory ops only).
    task automatic do_instr(input int op, input int fw, input int ew, input bit n, input bit z);
        for (int i = 0; i <= fw; i++) begin
            mem_rdy = (i == fw);
            opcode  = 4'($urandom);
            n_flag  = 1'($urandom);
            z_flag  = 1'($urandom);
            cycle_check("fetch", v_fetch(mem_rdy));
        end
        opcode = 4'(op);
        n_flag = n;
        z_flag = z;
        if (op <= 3) begin
            for (int i = 0; i <= ew; i++) begin
                mem_rdy = (i == ew);
                cycle_check("exec_mem", v_exec(op, mem_rdy, n, z));
            end
        end else begin
            mem_rdy = 1'($urandom);
            cycle_check("exec", v_exec(op, mem_rdy, n, z));
        end
        if (op == 7 || (TRAP && op >= 8)) begin
`ifdef MU0_ILLEGAL_TRAP_EN
            ill_model = (op >= 8);
`endif
            repeat (11) begin
                mem_rdy = 1'($urandom);
                opcode  = 4'($urandom);
                cycle_check("halt", v_halt());
            end
            do_reset();
        end
    endtask

    initial begin
        #1;
        check("reset_t0", {4'b0, observed()}, {4'b0, v_idle()});
        repeat (3) cycle_check("reset", v_idle());
        reset = 1'b0;

        do_instr(0, 0, 0, 0, 0);   // first fetch then LDA, no waits
        do_instr(0, 3, 0, 0, 0);   // fetch stalled 3 cycles
        do_instr(1, 0, 0, 0, 0);   // STA
        do_instr(2, 1, 2, 0, 0);   // ADD with waits
        do_instr(3, 0, 1, 0, 0);   // SUB
        do_instr(5, 0, 0, 1, 0);   // JGE not taken
        do_instr(5, 0, 0, 0, 1);   // JGE taken
        do_instr(6, 0, 0, 0, 1);   // JNE not taken
        do_instr(6, 0, 0, 1, 0);   // JNE taken
        do_instr(4, 0, 0, 1, 1);   // JMP
        do_instr(4'hA, 0, 0, 0, 0);
        do_instr(7, 0, 0, 0, 0);

        // Reset arriving during a fetch wait must drop the request immediately.
        mem_rdy = 1'b0;
        cycle_check("fetch_wait", v_fetch(1'b0));
        @(negedge clk);
        reset = 1'b1;
`ifdef MU0_ILLEGAL_TRAP_EN
        ill_model = 1'b0;
`endif
        #1;
        check("reset_midwait", {4'b0, observed()}, {4'b0, v_idle()});
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_instr(1, 2, 2, 0, 0);

        for (int k = 0; k < 300; k++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
            do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
